// File: rtl/q_update_scheduler_pkg.sv
// rtl/q_update_scheduler_pkg.sv - shared widths, tag record and helpers for the Q-update scheduler
package q_sched_pkg;

    localparam int FP_W = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Requester ids are sized for the largest supported requester count (8).
    localparam int NREQ_MAX = 8;
    localparam int ID_W     = clog2(NREQ_MAX);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/q_update_scheduler_rr_arbiter.sv
// rtl/q_update_scheduler_rr_arbiter.sv - combinational round-robin arbiter starting at ptr_i
module rr_arbiter
    import q_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] id_o
);

    logic any;

    // Scan from farthest to nearest so the requester closest to ptr_i wins.
    always_comb begin
        any  = 1'b0;
        id_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_i[i] && (((int'(ptr_i) + k) % NREQ) == i)) begin
                    any  = 1'b1;
                    id_o = ID_W'(i);
                end
            end
        end
        grant_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_o[i] = en_i && any && (id_o == ID_W'(i));
        end
    end

endmodule

// File: rtl/q_update_scheduler.sv
// rtl/q_update_scheduler.sv - shares one Q-function datapath among NREQ requesters
module q_update_scheduler
    import q_sched_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int DP_LATENCY     = 12,
    parameter int ISSUE_INTERVAL = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_x,
    input  logic [NREQ*FP_W-1:0] req_t,
    input  logic [NREQ*FP_W-1:0] req_n,
    input  logic [NREQ*FP_W-1:0] req_alpha,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]      rsp_q,
    output logic [FP_W-1:0]      dp_x,
    output logic [FP_W-1:0]      dp_t,
    output logic [FP_W-1:0]      dp_n,
    output logic [FP_W-1:0]      dp_alpha,
    output logic                 dp_valid,
    input  logic [FP_W-1:0]      dp_q,
    output logic                 busy
);

    localparam int CD_W = (ISSUE_INTERVAL > 1) ? clog2(ISSUE_INTERVAL) : 1;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CD_W-1:0]  cool_q, cool_d;
    logic             dpv_q;
    logic [ID_W-1:0]  dp_id_q;
    logic [FP_W-1:0]  x_q, t_q, n_q, a_q, res_q;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    tag_t             tag_q [DP_LATENCY];

    logic             issue_en, xfer;
    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  gnt_id;
    logic [FP_W-1:0]  sel_x, sel_t, sel_n, sel_a;

    assign issue_en = (cool_q == '0);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (issue_en),
        .grant_o (grant),
        .id_o    (gnt_id)
    );

    // Gated by reset so ready reads 0 while the block is held in reset.
    assign req_ready = grant & {NREQ{aresetn}};
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        sel_x = '0;
        sel_t = '0;
        sel_n = '0;
        sel_a = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_x = req_x[i*FP_W +: FP_W];
                sel_t = req_t[i*FP_W +: FP_W];
                sel_n = req_n[i*FP_W +: FP_W];
                sel_a = req_alpha[i*FP_W +: FP_W];
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        cool_d = cool_q;
        if (xfer) begin
            ptr_d  = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + ID_W'(1);
            cool_d = CD_W'(ISSUE_INTERVAL - 1);
        end else if (cool_q != '0) begin
            cool_d = cool_q - CD_W'(1);
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_d[i] = tag_q[DP_LATENCY-1].vld && (tag_q[DP_LATENCY-1].id == ID_W'(i));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q       <= '0;
            cool_q      <= '0;
            dpv_q       <= 1'b0;
            dp_id_q     <= '0;
            x_q         <= '0;
            t_q         <= '0;
            n_q         <= '0;
            a_q         <= '0;
            res_q       <= '0;
            rsp_valid_q <= '0;
            for (int k = 0; k < DP_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cool_q      <= cool_d;
            dpv_q       <= xfer;
            rsp_valid_q <= rsp_valid_d;
            if (xfer) begin
                dp_id_q <= gnt_id;
                x_q     <= sel_x;
                t_q     <= sel_t;
                n_q     <= sel_n;
                a_q     <= sel_a;
            end
            // Slot DP_LATENCY-1 lines up with the cycle dp_q holds that issue's result.
            tag_q[0] <= '{vld: dpv_q, id: dp_id_q};
            for (int k = 1; k < DP_LATENCY; k++) tag_q[k] <= tag_q[k-1];
            if (tag_q[DP_LATENCY-1].vld) res_q <= dp_q;
        end
    end

    always_comb begin
        busy = dpv_q;
        for (int k = 0; k < DP_LATENCY; k++) busy = busy | tag_q[k].vld;
    end

    assign dp_x      = x_q;
    assign dp_t      = t_q;
    assign dp_n      = n_q;
    assign dp_alpha  = a_q;
    assign dp_valid  = dpv_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = res_q;

endmodule

// File: tb/tb_q_update_scheduler.sv
// tb/tb_q_update_scheduler.sv - bench for q_update_scheduler: event-history model plus directed checks
module tb_q_update_scheduler;

    localparam int NREQ = 4;
    localparam int FPW  = 32;
    localparam int L    = 12;
    localparam int NU   = 2;
    localparam int HSZ  = 4096;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic aresetn = 1'b1;

    logic [NREQ-1:0]     rv [NU];
    logic [NREQ-1:0]     rr [NU];
    logic [NREQ*FPW-1:0] rx [NU];
    logic [NREQ*FPW-1:0] rt [NU];
    logic [NREQ*FPW-1:0] rn [NU];
    logic [NREQ*FPW-1:0] ra [NU];
    logic [NREQ-1:0]     sv [NU];
    logic [FPW-1:0]      sq [NU];
    logic [FPW-1:0]      dx [NU];
    logic [FPW-1:0]      dt [NU];
    logic [FPW-1:0]      dn [NU];
    logic [FPW-1:0]      da [NU];
    logic [FPW-1:0]      dq [NU];
    logic                dv [NU];
    logic                by [NU];

    q_update_scheduler #(.NREQ(NREQ), .DP_LATENCY(L), .ISSUE_INTERVAL(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_x(rx[0]), .req_t(rt[0]), .req_n(rn[0]), .req_alpha(ra[0]),
        .rsp_valid(sv[0]), .rsp_q(sq[0]), .dp_x(dx[0]), .dp_t(dt[0]), .dp_n(dn[0]),
        .dp_alpha(da[0]), .dp_valid(dv[0]), .dp_q(dq[0]), .busy(by[0])
    );

    q_update_scheduler #(.NREQ(NREQ), .DP_LATENCY(L), .ISSUE_INTERVAL(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_x(rx[1]), .req_t(rt[1]), .req_n(rn[1]), .req_alpha(ra[1]),
        .rsp_valid(sv[1]), .rsp_q(sq[1]), .dp_x(dx[1]), .dp_t(dt[1]), .dp_n(dn[1]),
        .dp_alpha(da[1]), .dp_valid(dv[1]), .dp_q(dq[1]), .busy(by[1])
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int ii_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Model: per-cycle history of transfers (requester id or -1) and dp_q samples.
    int             xid      [NU][HSZ];
    logic [FPW-1:0] dqh      [NU][HSZ];
    int             last_rst [NU] = '{0, 0};
    int             ptr_m    [NU] = '{0, 0};
    logic [127:0]   exp_dp   [NU];
    logic [FPW-1:0] exp_rq   [NU];
    logic [NREQ-1:0] acc     [NU];
    bit             rmode    [NU] = '{0, 0};
    bit             dq_rand  [NU] = '{0, 1};
    int             pct      [NU] = '{0, 0};

    function automatic bit xfer_at(input int u, input int c);
        return (c > last_rst[u]) && (xid[u][c] >= 0);
    endfunction

    task automatic model_step(input int u);
        int n;
        logic [NREQ-1:0] e_rdy, e_sv;
        bit e_dv, e_by, en;
        int g;
        n = cyc;
        dqh[u][n] = dq[u];
        xid[u][n] = -1;
        acc[u] = rv[u] & rr[u];
        if (!aresetn) begin
            last_rst[u] = n;
            ptr_m[u]    = 0;
            exp_dp[u]   = '0;
            exp_rq[u]   = '0;
            chk($sformatf("u%0d reset_outputs", u), {rr[u], sv[u], dv[u], by[u], sq[u]}, '0);
            chk($sformatf("u%0d reset_dp_ops", u), {dx[u], dt[u], dn[u], da[u]}, '0);
            return;
        end
        e_dv = xfer_at(u, n - 1);
        e_sv = '0;
        if (xfer_at(u, n - L - 2)) begin
            e_sv = NREQ'(1) << xid[u][n-L-2];
            exp_rq[u] = dqh[u][n-1];
        end
        e_by = 1'b0;
        for (int c = n - L - 1; c <= n - 1; c++) if (xfer_at(u, c)) e_by = 1'b1;
        en = 1'b1;
        for (int c = n - ii_of(u) + 1; c <= n - 1; c++) if (xfer_at(u, c)) en = 1'b0;
        e_rdy = '0;
        g = -1;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && rv[u][(ptr_m[u] + k) % NREQ]) g = (ptr_m[u] + k) % NREQ;
            end
            if (g >= 0) e_rdy[g] = 1'b1;
        end
        chk($sformatf("u%0d req_ready", u), rr[u], e_rdy);
        chk($sformatf("u%0d dp_valid", u), dv[u], e_dv);
        chk($sformatf("u%0d dp_ops", u), {dx[u], dt[u], dn[u], da[u]}, exp_dp[u]);
        chk($sformatf("u%0d rsp_valid", u), sv[u], e_sv);
        chk($sformatf("u%0d rsp_q", u), sq[u], exp_rq[u]);
        chk($sformatf("u%0d busy", u), by[u], e_by);
        if (g >= 0) begin
            xid[u][n] = g;
            ptr_m[u]  = (g + 1) % NREQ;
            exp_dp[u] = {rx[u][g*FPW +: FPW], rt[u][g*FPW +: FPW], rn[u][g*FPW +: FPW], ra[u][g*FPW +: FPW]};
        end
    endtask

    always @(negedge aclk) begin
        if (cyc < HSZ) begin
            for (int u = 0; u < NU; u++) model_step(u);
        end
    end

    // Random requesters obey the hold rule: operands change only after acceptance.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            for (int u = 0; u < NU; u++) begin
                if (dq_rand[u]) dq[u] = $urandom;
                if (rmode[u]) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (acc[u][i] || !rv[u][i]) begin
                            rv[u][i] = 1'b0;
                            if ($urandom_range(99) < pct[u]) begin
                                rv[u][i] = 1'b1;
                                rx[u][i*FPW +: FPW] = $urandom;
                                rt[u][i*FPW +: FPW] = $urandom;
                                rn[u][i*FPW +: FPW] = $urandom;
                                ra[u][i*FPW +: FPW] = $urandom;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_hs(input int u, output int c, output int id);
        c  = -1;
        id = -1;
        for (int k = 0; k < 60 && c < 0; k++) begin
            @(negedge aclk);
            if ((rv[u] & rr[u]) != '0) begin
                c  = cyc;
                id = oh2i(rv[u] & rr[u]);
            end
        end
        chk($sformatf("u%0d hs_timeout", u), (c >= 0), 1'b1);
    endtask

    task automatic do_reset();
        @(posedge aclk); #1; aresetn = 1'b0;
        @(posedge aclk); #1; aresetn = 1'b1;
    endtask

    initial begin
        int c, id, cp, idp;
        for (int u = 0; u < NU; u++) begin
            rv[u] = '0; rx[u] = '0; rt[u] = '0; rn[u] = '0; ra[u] = '0; dq[u] = '0; acc[u] = '0;
        end
        #2 aresetn = 1'b0;
        @(negedge aclk);
        chk("reset dp_valid", dv[0], 1'b0);
        chk("reset busy", by[0], 1'b0);
        chk("reset rsp_q", sq[0], '0);
        @(posedge aclk); #1; aresetn = 1'b1;

        // Single request on requester 2.
        dq[0] = 32'h42C80000;
        rv[0] = 4'b0100;
        rx[0][2*FPW +: FPW] = 32'h42000000;
        rt[0][2*FPW +: FPW] = 32'h425C0000;
        rn[0][2*FPW +: FPW] = 32'h42CA0000;
        ra[0][2*FPW +: FPW] = 32'h40000000;
        wait_hs(0, c, id);
        chk("single grant id", id, 2);
        @(posedge aclk); #1;
        rv[0] = '0;
        rx[0][2*FPW +: FPW] = 32'h3F800000;
        @(negedge aclk);
        chk("single dp_valid", dv[0], 1'b1);
        chk("single dp_x", dx[0], 32'h42000000);
        chk("single dp_n", dn[0], 32'h42CA0000);
        while (cyc < c + 13) @(negedge aclk);
        chk("single rsp early", sv[0], 4'b0000);
        @(negedge aclk);
        chk("single rsp_valid", sv[0], 4'b0100);
        chk("single rsp_q", sq[0], 32'h42C80000);
        chk("operand hold dp_x", dx[0], 32'h42000000);
        dq_rand[0] = 1'b1;

        // All four requesters continuously valid.
        do_reset();
        pct[0] = 100; rmode[0] = 1'b1;
        cp = -1;
        for (int k = 0; k < 6; k++) begin
            wait_hs(0, c, id);
            chk($sformatf("rr order %0d", k), id, k % NREQ);
            if (cp >= 0) chk($sformatf("rr spacing %0d", k), c - cp, 4);
            cp = c;
        end
        @(posedge aclk); #1;
        rmode[0] = 1'b0; rv[0] = '0;
        repeat (20) @(posedge aclk);

        // Fairness: requester 0 always valid, requester 3 joins later.
        do_reset();
        rv[0] = 4'b0001;
        wait_hs(0, cp, idp);
        chk("fair first", idp, 0);
        @(posedge aclk); #1; rv[0][3] = 1'b1;
        wait_hs(0, c, id);
        chk("fair req3 id", id, 3);
        chk("fair req3 spacing", c - cp, 4);
        @(posedge aclk); #1; rv[0][3] = 1'b0;
        wait_hs(0, cp, idp);
        chk("fair back to 0", idp, 0);
        chk("fair back spacing", cp - c, 4);

        // Reset with two updates in flight.
        do_reset();
        rv[0] = 4'b0011;
        wait_hs(0, c, id);
        @(posedge aclk); #1; rv[0][0] = 1'b0;
        wait_hs(0, c, id);
        chk("midrst second id", id, 1);
        @(posedge aclk); #1; rv[0] = '0;
        repeat (4) @(posedge aclk);
        #1 aresetn = 1'b0;
        #1;
        chk("midrst immediate", {dv[0], by[0], sv[0], rr[0], dx[0], sq[0]}, '0);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            chk("midrst no rsp", sv[0], 4'b0000);
            chk("midrst busy", by[0], 1'b0);
        end

        // Back-to-back issue on the interval-1 instance.
        @(posedge aclk); #1; rv[1] = 4'b0010;
        wait_hs(1, c, id);
        for (int k = 0; k < 20; k++) begin
            @(posedge aclk); #1;
            rx[1][FPW +: FPW] = $urandom;
            rn[1][FPW +: FPW] = $urandom;
            @(negedge aclk);
            chk("ii1 dp_valid", dv[1], 1'b1);
            chk("ii1 ready", rr[1], 4'b0010);
        end
        @(posedge aclk); #1; rv[1] = '0;
        repeat (20) @(posedge aclk);

        // Random traffic on both instances.
        pct[0] = 30; pct[1] = 70;
        rmode[0] = 1'b1; rmode[1] = 1'b1;
        repeat (1500) @(posedge aclk);
        #1;
        rmode[0] = 1'b0; rmode[1] = 1'b0;
        rv[0] = '0; rv[1] = '0;
        repeat (30) @(posedge aclk);
        @(negedge aclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
